// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant start value, FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam int         AES_KEY_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } ke_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load and round-key handshake bundle between the key source, the schedule and addRoundKey.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic [AES_KEY_W-1:0] key_in;
  logic                 key_valid;
  logic                 key_ready;
  logic [AES_KEY_W-1:0] rk_out;
  logic [3:0]           rk_round;
  logic                 rk_valid;
  logic                 rk_ready;
  logic                 done;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_valid, done
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_valid, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_b;

  assign inv_b = gf_inv(din);
  assign dout  = inv_b
               ^ {inv_b[6:0], inv_b[7]}
               ^ {inv_b[5:0], inv_b[7:6]}
               ^ {inv_b[4:0], inv_b[7:5]}
               ^ {inv_b[3:0], inv_b[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// On-the-fly AES-128 key schedule: loads one cipher key and presents round keys 0..NR in order,
// advancing one expansion step per accepted round key.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_expand_if.slave    kif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ke_state_t            state_q;
  logic [AES_KEY_W-1:0] rk_q;
  logic [3:0]           round_q;
  logic [7:0]           rcon_q;
  logic                 rk_valid_q;
  logic                 key_ready_q;
  logic                 done_q;

  logic                 key_fire;
  logic                 rk_fire;
  logic [31:0]          w0, w1, w2, w3;
  logic [31:0]          rot_w, sub_w, t_w;
  logic [31:0]          n0, n1, n2, n3;
  logic [AES_KEY_W-1:0] rk_next;

  assign key_fire = kif.key_valid & key_ready_q;
  assign rk_fire  = rk_valid_q & kif.rk_ready;

  // Next-key datapath: SubWord(RotWord(w3)) straight off the rk_q register, then the XOR chain.
  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot_w[8*i +: 8]),
      .dout (sub_w[8*i +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ t_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rk_q        <= '0;
      round_q     <= '0;
      rcon_q      <= RCON_INIT;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Entering IDLE with key_ready low gives the one-cycle gap after done.
          key_ready_q <= 1'b1;
          if (key_fire) begin
            rk_q        <= kif.key_in;
            round_q     <= '0;
            rcon_q      <= RCON_INIT;
            rk_valid_q  <= 1'b1;
            key_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (rk_fire) begin
            if (round_q == LAST_ROUND) begin
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              rk_q    <= rk_next;
              round_q <= round_q + 4'd1;
              rcon_q  <= xtime(rcon_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kif.key_ready = key_ready_q;
  assign kif.rk_out    = rk_q;
  assign kif.rk_round  = round_q;
  assign kif.rk_valid  = rk_valid_q;
  assign kif.done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 known answers plus random keys against a table-driven key schedule model.
module tb_aes_key_expand;

  localparam logic [127:0] K_A1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2_A1   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_SEQ = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [7:0]   RC [10]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef logic [10:0][127:0] sched_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_key_expand_if kif ();

  aes_key_expand #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_sbox();
    logic [2047:0] flat;
    flat = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = flat[2047-8*i -: 8];
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Textbook word-by-word KeyExpansion over w[0..43].
  function automatic sched_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RC[i/4-1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents a key until the handshake happens; returns at the negedge where round key 0 should show.
  task automatic load_key(input logic [127:0] k, output bit ok);
    int n;
    n = 0;
    kif.key_in    = k;
    kif.key_valid = 1'b1;
    while (kif.key_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (kif.key_ready === 1'b1);
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({kif.key_ready, kif.rk_valid, kif.rk_round, kif.done} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got kr=%b v=%b r=%0d d=%b required kr=1 v=0 r=0 d=0",
               kif.key_ready, kif.rk_valid, kif.rk_round, kif.done);
    end
    checks++;
    if (kif.rk_out !== 128'h0) begin
      errors++;
      $display("FAIL reset_rk_out got %h required 0", kif.rk_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({kif.key_ready, kif.rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle got kr=%b v=%b required kr=1 v=0", kif.key_ready, kif.rk_valid);
    end
  endtask

  task automatic test_fips();
    sched_t       e;
    bit           ok;
    int           done_cnt;
    logic [127:0] kat;
    e        = expand(K_A1);
    done_cnt = 0;
    kif.rk_ready = 1'b1;
    load_key(K_A1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fips_load key_ready=%b required 1", kif.key_ready);
    end
    for (int c = 1; c <= 13; c++) begin
      if (c <= 11) begin
        checks++;
        if ({kif.rk_valid, kif.rk_round, kif.rk_out} !== {1'b1, 4'(c-1), e[c-1]}) begin
          errors++;
          $display("FAIL fips_rk%0d got v=%b r=%0d %h required v=1 r=%0d %h",
                   c-1, kif.rk_valid, kif.rk_round, kif.rk_out, c-1, e[c-1]);
        end
      end
      if (c == 1 || c == 2 || c == 3 || c == 11) begin
        kat = (c == 1) ? K_A1 : (c == 2) ? RK1_A1 : (c == 3) ? RK2_A1 : RK10_A1;
        checks++;
        if (kif.rk_out !== kat) begin
          errors++;
          $display("FAIL fips_kat_cycle%0d got %h required %h", c, kif.rk_out, kat);
        end
      end
      if (kif.done === 1'b1) done_cnt++;
      if (c == 12) begin
        checks++;
        if ({kif.done, kif.key_ready, kif.rk_valid} !== 3'b100) begin
          errors++;
          $display("FAIL fips_done got d=%b kr=%b v=%b required d=1 kr=0 v=0",
                   kif.done, kif.key_ready, kif.rk_valid);
        end
      end
      if (c == 13) begin
        checks++;
        if ({kif.done, kif.key_ready} !== 2'b01) begin
          errors++;
          $display("FAIL fips_key_ready got d=%b kr=%b required d=0 kr=1", kif.done, kif.key_ready);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL fips_done_count got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    sched_t       e;
    bit           ok;
    int           got;
    bit           have_prev;
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = (n == 0) ? K_A1 : rand_key();
      e = expand(k);
      kif.rk_ready = 1'b0;
      load_key(k, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_load key%0d key_ready=%b required 1", n, kif.key_ready);
      end
      got       = 0;
      have_prev = 1'b0;
      for (int c = 0; c < 300 && got < 11; c++) begin
        if (have_prev) begin
          checks++;
          if (kif.rk_out !== prev_out || kif.rk_round !== prev_round || kif.rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall key%0d got r=%0d %h required r=%0d %h",
                     n, kif.rk_round, kif.rk_out, prev_round, prev_out);
          end
        end
        kif.rk_ready = ($urandom_range(0, 99) < 30);
        if (kif.rk_valid === 1'b1 && kif.rk_ready) begin
          checks++;
          if (kif.rk_round !== 4'(got) || kif.rk_out !== e[got]) begin
            errors++;
            $display("FAIL bp_rk key%0d got r=%0d %h required r=%0d %h",
                     n, kif.rk_round, kif.rk_out, got, e[got]);
          end
          got++;
          have_prev = 1'b0;
        end else begin
          have_prev  = (kif.rk_valid === 1'b1);
          prev_out   = kif.rk_out;
          prev_round = kif.rk_round;
        end
        @(negedge clk);
      end
      checks++;
      if (got != 11 || kif.rk_valid !== 1'b0 || kif.done !== 1'b1) begin
        errors++;
        $display("FAIL bp_end key%0d got count=%0d v=%b d=%b required count=11 v=0 d=1",
                 n, got, kif.rk_valid, kif.done);
      end
    end
    kif.rk_ready = 1'b0;
  endtask

  task automatic test_key_ignored();
    logic [127:0] ka, kb;
    sched_t       ea, eb;
    int           n;
    ka = rand_key();
    kb = rand_key();
    ea = expand(ka);
    eb = expand(kb);
    kif.rk_ready  = 1'b1;
    kif.key_in    = ka;
    kif.key_valid = 1'b1;
    n = 0;
    while (kif.key_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (kif.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL ign_load key_ready=%b required 1", kif.key_ready);
    end
    @(negedge clk);
    kif.key_in = kb;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 11) begin
        checks++;
        if ({kif.key_ready, kif.rk_valid, kif.rk_round, kif.rk_out} !== {1'b0, 1'b1, 4'(c-1), ea[c-1]}) begin
          errors++;
          $display("FAIL ign_run cycle%0d got kr=%b v=%b r=%0d %h required kr=0 v=1 r=%0d %h",
                   c, kif.key_ready, kif.rk_valid, kif.rk_round, kif.rk_out, c-1, ea[c-1]);
        end
      end else if (c == 12) begin
        checks++;
        if ({kif.done, kif.key_ready} !== 2'b10) begin
          errors++;
          $display("FAIL ign_done got d=%b kr=%b required d=1 kr=0", kif.done, kif.key_ready);
        end
      end else if (c == 13) begin
        checks++;
        if ({kif.key_ready, kif.rk_valid} !== 2'b10) begin
          errors++;
          $display("FAIL ign_reload got kr=%b v=%b required kr=1 v=0", kif.key_ready, kif.rk_valid);
        end
      end else if (c <= 24) begin
        if (c == 14) kif.key_valid = 1'b0;
        checks++;
        if ({kif.rk_valid, kif.rk_round, kif.rk_out} !== {1'b1, 4'(c-14), eb[c-14]}) begin
          errors++;
          $display("FAIL ign_second_rk%0d got v=%b r=%0d %h required v=1 r=%0d %h",
                   c-14, kif.rk_valid, kif.rk_round, kif.rk_out, c-14, eb[c-14]);
        end
      end else begin
        checks++;
        if (kif.done !== 1'b1) begin
          errors++;
          $display("FAIL ign_second_done got %b required 1", kif.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] kx;
    sched_t       e, e2;
    bit           ok;
    kx = rand_key();
    e  = expand(kx);
    kif.rk_ready = 1'b1;
    load_key(kx, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || kif.rk_round !== 4'd5 || kif.rk_out !== e[5]) begin
      errors++;
      $display("FAIL rst_pre got ok=%b r=%0d %h required ok=1 r=5 %h", ok, kif.rk_round, kif.rk_out, e[5]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kif.key_ready, kif.rk_valid, kif.rk_round, kif.done, kif.rk_out} !== {1'b1, 1'b0, 4'd0, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL rst_async got kr=%b v=%b r=%0d d=%b %h required kr=1 v=0 r=0 d=0 0",
               kif.key_ready, kif.rk_valid, kif.rk_round, kif.done, kif.rk_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({kif.key_ready, kif.rk_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_release got kr=%b v=%b required kr=1 v=0", kif.key_ready, kif.rk_valid);
    end
    e2 = expand(K_SEQ);
    load_key(K_SEQ, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_reload key_ready=%b required 1", kif.key_ready);
    end
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) begin
        checks++;
        if ({kif.rk_valid, kif.rk_round, kif.rk_out} !== {1'b1, 4'(c-1), e2[c-1]}) begin
          errors++;
          $display("FAIL rst_seq_rk%0d got v=%b r=%0d %h required v=1 r=%0d %h",
                   c-1, kif.rk_valid, kif.rk_round, kif.rk_out, c-1, e2[c-1]);
        end
      end
      if (c == 11) begin
        checks++;
        if (kif.rk_out !== RK10_SEQ) begin
          errors++;
          $display("FAIL rst_seq_kat got %h required %h", kif.rk_out, RK10_SEQ);
        end
      end
      if (c == 12) begin
        checks++;
        if (kif.done !== 1'b1) begin
          errors++;
          $display("FAIL rst_seq_done got %b required 1", kif.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [3];
    sched_t       e [3];
    int           n;
    for (int k = 0; k < 3; k++) begin
      keys[k] = rand_key();
      e[k]    = expand(keys[k]);
    end
    kif.rk_ready  = 1'b1;
    kif.key_in    = keys[0];
    kif.key_valid = 1'b1;
    n = 0;
    while (kif.key_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (kif.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load key_ready=%b required 1", kif.key_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) kif.key_in = keys[k+1];
      else       kif.key_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
        checks++;
        if ({kif.rk_valid, kif.rk_round, kif.rk_out} !== {1'b1, 4'(c-1), e[k][c-1]}) begin
          errors++;
          $display("FAIL b2b_key%0d_rk%0d got v=%b r=%0d %h required v=1 r=%0d %h",
                   k, c-1, kif.rk_valid, kif.rk_round, kif.rk_out, c-1, e[k][c-1]);
        end
        @(negedge clk);
      end
      checks++;
      if ({kif.done, kif.rk_valid} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_key%0d_done got d=%b v=%b required d=1 v=0", k, kif.done, kif.rk_valid);
      end
      @(negedge clk);
      checks++;
      if ({kif.rk_valid, kif.key_ready, kif.done} !== 3'b010) begin
        errors++;
        $display("FAIL b2b_key%0d_gap got v=%b kr=%b d=%b required v=0 kr=1 d=0",
                 k, kif.rk_valid, kif.key_ready, kif.done);
      end
    end
    @(negedge clk);
    checks++;
    if (kif.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_quiet got v=%b required 0", kif.rk_valid);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    kif.key_in    = '0;
    kif.key_valid = 1'b0;
    kif.rk_ready  = 1'b0;
    init_sbox();
    repeat (2) @(negedge clk);
    test_reset();
    test_fips();
    test_backpressure();
    test_key_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
